// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: decodes host command frames arriving as a UART byte stream,
// issues one read or write on the peripheral register bus and streams back a
// status/data response. Optional bus-wait timeout is compiled in with the
// BRIDGE_TIMEOUT_EN macro; without it WAIT blocks until the bus answers.
module uart_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        write_o,
    output logic [7:0]  write_address_o,
    output logic [31:0] write_data_o,
    input  logic        write_done_i,
    input  logic        write_error_i,
    output logic        read_o,
    output logic [7:0]  read_address_o,
    input  logic [31:0] read_data_i,
    input  logic        read_done_i,
    input  logic        read_error_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_REQ  = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE  = 8'hA5;
    localparam logic [7:0] CMD_READ   = 8'h5A;
    localparam logic [7:0] RSP_OK     = 8'h00;
    localparam logic [7:0] RSP_BUSERR = 8'hEE;
    localparam logic [7:0] RSP_TMO    = 8'hED;
    localparam logic [7:0] RSP_BADCMD = 8'h3F;

    state_t      r_state;
    logic        r_is_write;
    logic [7:0]  r_addr;
    logic [23:0] r_data_buf;
    logic [1:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [2:0]  r_idx;
    logic [2:0]  r_resp_last;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_write;
    logic        r_read;
    logic [7:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [7:0]  r_raddr;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_timer;
`endif

    logic       w_rx_ready;
    logic       w_rx_fire;
    logic       w_tx_fire;
    logic       w_done;
    logic       w_err;
    logic [7:0] w_next_byte;

    // Handshake qualifiers and the done/error of the direction in flight only.
    always_comb begin
        w_rx_ready = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
        w_rx_fire  = rx_valid_i && w_rx_ready;
        w_tx_fire  = r_tx_valid && tx_ready_i;
        if (r_is_write) begin
            w_done = write_done_i;
            w_err  = write_error_i;
        end else begin
            w_done = read_done_i;
            w_err  = read_error_i;
        end
    end

    // Data byte that follows response byte r_idx (read data, little-endian).
    always_comb begin
        case (r_idx)
            3'd0:    w_next_byte = r_rdata[7:0];
            3'd1:    w_next_byte = r_rdata[15:8];
            3'd2:    w_next_byte = r_rdata[23:16];
            3'd3:    w_next_byte = r_rdata[31:24];
            default: w_next_byte = 8'h00;
        endcase
    end

    // Command FSM: frame decode, bus request pulse, wait for done, response shift-out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_is_write  <= 1'b0;
            r_addr      <= 8'h00;
            r_data_buf  <= 24'h000000;
            r_cnt       <= 2'd0;
            r_rdata     <= 32'h00000000;
            r_idx       <= 3'd0;
            r_resp_last <= 3'd0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_waddr     <= 8'h00;
            r_wdata     <= 32'h00000000;
            r_raddr     <= 8'h00;
`ifdef BRIDGE_TIMEOUT_EN
            r_timer     <= '0;
`endif
        end else begin
            r_write <= 1'b0;
            r_read  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        if (rx_data_i == CMD_WRITE) begin
                            r_is_write <= 1'b1;
                            r_state    <= S_ADDR;
                        end else if (rx_data_i == CMD_READ) begin
                            r_is_write <= 1'b0;
                            r_state    <= S_ADDR;
                        end else begin
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= RSP_BADCMD;
                            r_idx       <= 3'd0;
                            r_resp_last <= 3'd0;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr <= rx_data_i;
                        if (r_is_write) begin
                            r_cnt   <= 2'd0;
                            r_state <= S_DATA;
                        end else begin
                            r_raddr <= rx_data_i;
                            r_read  <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        case (r_cnt)
                            2'd0:    r_data_buf[7:0]   <= rx_data_i;
                            2'd1:    r_data_buf[15:8]  <= rx_data_i;
                            2'd2:    r_data_buf[23:16] <= rx_data_i;
                            default: r_data_buf        <= r_data_buf;
                        endcase
                        if (r_cnt == 2'd3) begin
                            r_wdata <= {rx_data_i, r_data_buf};
                            r_waddr <= r_addr;
                            r_write <= 1'b1;
                            r_cnt   <= 2'd0;
                            r_state <= S_REQ;
                        end else begin
                            r_cnt <= r_cnt + 2'd1;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    if (w_done) begin
                        r_rdata     <= read_data_i;
                        r_tx_valid  <= 1'b1;
                        r_idx       <= 3'd0;
                        r_state     <= S_RESP;
                        if (w_err) begin
                            r_tx_data   <= RSP_BUSERR;
                            r_resp_last <= 3'd0;
                        end else if (r_is_write) begin
                            r_tx_data   <= RSP_OK;
                            r_resp_last <= 3'd0;
                        end else begin
                            r_tx_data   <= RSP_OK;
                            r_resp_last <= 3'd4;
                        end
                    end else if (r_state == S_REQ) begin
`ifdef BRIDGE_TIMEOUT_EN
                        r_timer <= TW'(TIMEOUT_CYCLES - 1);
`endif
                        r_state <= S_WAIT;
                    end else begin
`ifdef BRIDGE_TIMEOUT_EN
                        if (r_timer == '0) begin
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= RSP_TMO;
                            r_idx       <= 3'd0;
                            r_resp_last <= 3'd0;
                            r_state     <= S_RESP;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
`else
                        r_state <= S_WAIT;
`endif
                    end
                end
                S_RESP: begin
                    if (w_tx_fire) begin
                        if (r_idx == r_resp_last) begin
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_idx      <= 3'd0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_tx_data <= w_next_byte;
                            r_idx     <= r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready_o      = w_rx_ready;
    assign busy_o          = (r_state != S_IDLE);
    assign tx_valid_o      = r_tx_valid;
    assign tx_data_o       = r_tx_data;
    assign write_o         = r_write;
    assign write_address_o = r_waddr;
    assign write_data_o    = r_wdata;
    assign read_o          = r_read;
    assign read_address_o  = r_raddr;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: drives host frames and bus completions,
// scoreboards the response byte stream and checks bus pulses and timing.
module tb_uart_bus_bridge;

    localparam int TO = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic        write_o;
    logic [7:0]  write_address_o;
    logic [31:0] write_data_o;
    logic        write_done_i = 1'b0;
    logic        write_error_i = 1'b0;
    logic        read_o;
    logic [7:0]  read_address_o;
    logic [31:0] read_data_i = 32'h0;
    logic        read_done_i = 1'b0;
    logic        read_error_i = 1'b0;
    logic        busy_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [7:0]  exp_q[$];
    logic        toggle_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    uart_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .write_o(write_o), .write_address_o(write_address_o), .write_data_o(write_data_o),
        .write_done_i(write_done_i), .write_error_i(write_error_i),
        .read_o(read_o), .read_address_o(read_address_o), .read_data_i(read_data_i),
        .read_done_i(read_done_i), .read_error_i(read_error_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Transmitter model: ready either held high or toggled every cycle.
    always @(posedge clk_i) begin
        #2;
        if (toggle_ready) tx_ready_i = ~tx_ready_i;
        else              tx_ready_i = 1'b1;
    end

    // Response monitor: scoreboard pop on each handshake, hold check while stalled.
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (write_o) wr_pulses++;
            if (read_o)  rd_pulses++;
            if (prev_stall) begin
                n_checks++;
                if (tx_valid_o !== 1'b1 || tx_data_o !== prev_data) begin
                    n_fail++;
                    $display("FAIL tx_hold: valid=%b data=%h required valid=1 data=%h", tx_valid_o, tx_data_o, prev_data);
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte %h, required none", tx_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data_o !== e) begin
                        n_fail++;
                        $display("FAIL tx_byte: got %h required %h", tx_data_o, e);
                    end
                end
            end
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_data  = tx_data_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (!rx_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_handshake: rx_ready=0 required 1 for byte %h", b);
        end
        @(negedge clk_i);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(rx_ready_o && exp_q.size() == 0) && k < 300) begin
            @(negedge clk_i);
            k++;
        end
        n_checks++;
        if (!(rx_ready_o && exp_q.size() == 0)) begin
            n_fail++;
            $display("FAIL wait_idle: rx_ready=%b pending=%0d required rx_ready=1 pending=0", rx_ready_o, exp_q.size());
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({rx_ready_o, tx_valid_o, write_o, read_o, busy_o} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/txv/wr/rd/busy=%b required 10000", {rx_ready_o, tx_valid_o, write_o, read_o, busy_o});
        end
        n_checks++;
        if (tx_data_o !== 8'h00 || write_address_o !== 8'h00 || read_address_o !== 8'h00 || write_data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: tx=%h wa=%h ra=%h wd=%h required all 0", tx_data_o, write_address_o, read_address_o, write_data_o);
        end
        // Done strobes while idle must be ignored.
        write_done_i = 1'b1;
        read_done_i  = 1'b1;
        @(negedge clk_i);
        write_done_i = 1'b0;
        read_done_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done_ignored: txv=%b busy=%b required 0 0", tx_valid_o, busy_o);
        end
    endtask

    task automatic test_write_ok();
        int w0;
        w0 = wr_pulses;
        exp_q.push_back(8'h00);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h78);
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        rx_valid_i = 1'b0;
        n_checks++;
        if (write_o !== 1'b1 || write_address_o !== 8'h10 || write_data_o !== 32'h12345678) begin
            n_fail++;
            $display("FAIL write_req: wr=%b addr=%h data=%h required 1 10 12345678", write_o, write_address_o, write_data_o);
        end
        n_checks++;
        if (busy_o !== 1'b1 || rx_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_busy: busy=%b rdy=%b required 1 0", busy_o, rx_ready_o);
        end
        @(negedge clk_i);
        read_done_i = 1'b1;
        n_checks++;
        if (write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_pulse_width: wr=%b required 0", write_o);
        end
        @(negedge clk_i);
        read_done_i = 1'b0;
        @(negedge clk_i);
        write_done_i = 1'b1;
        n_checks++;
        if (tx_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL write_early_resp: txv=%b required 0", tx_valid_o);
        end
        @(negedge clk_i);
        write_done_i = 1'b0;
        n_checks++;
        if (tx_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL write_resp_latency: txv=%b required 1", tx_valid_o);
        end
        wait_idle();
        n_checks++;
        if (wr_pulses - w0 !== 1) begin
            n_fail++;
            $display("FAIL write_pulse_count: got %0d required 1", wr_pulses - w0);
        end
    endtask

    task automatic test_read_ok();
        int r0;
        r0 = rd_pulses;
        exp_q.push_back(8'h00); exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        send_byte(8'h5A); send_byte(8'h04);
        rx_valid_i = 1'b0;
        n_checks++;
        if (read_o !== 1'b1 || read_address_o !== 8'h04) begin
            n_fail++;
            $display("FAIL read_req: rd=%b addr=%h required 1 04", read_o, read_address_o);
        end
        // Done in the same cycle as the request pulse.
        read_done_i = 1'b1;
        read_data_i = 32'hDEADBEEF;
        @(negedge clk_i);
        read_done_i = 1'b0;
        read_data_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (tx_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL read_stream: byte %0d txv=%b required 1", i, tx_valid_o);
            end
            @(negedge clk_i);
        end
        n_checks++;
        if (tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL read_return_idle: txv=%b rdy=%b required 0 1", tx_valid_o, rx_ready_o);
        end
        wait_idle();
        n_checks++;
        if (rd_pulses - r0 !== 1) begin
            n_fail++;
            $display("FAIL read_pulse_count: got %0d required 1", rd_pulses - r0);
        end
    endtask

    task automatic test_bus_error();
        exp_q.push_back(8'hEE);
        send_byte(8'h5A); send_byte(8'h08);
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        read_done_i  = 1'b1;
        read_error_i = 1'b1;
        read_data_i  = 32'h11223344;
        @(negedge clk_i);
        read_done_i  = 1'b0;
        read_error_i = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk_i);
        n_checks++;
        if (rx_ready_o !== 1'b1 || tx_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_error_idle: rdy=%b txv=%b required 1 0", rx_ready_o, tx_valid_o);
        end
    endtask

    task automatic test_bad_cmd();
        int w0, r0;
        w0 = wr_pulses;
        r0 = rd_pulses;
        exp_q.push_back(8'h3F);
        send_byte(8'h33);
        rx_valid_i = 1'b0;
        n_checks++;
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h3F) begin
            n_fail++;
            $display("FAIL bad_cmd_resp: txv=%b data=%h required 1 3f", tx_valid_o, tx_data_o);
        end
        wait_idle();
        n_checks++;
        if (wr_pulses != w0 || rd_pulses != r0) begin
            n_fail++;
            $display("FAIL bad_cmd_no_pulse: wr=%0d rd=%0d required 0 0", wr_pulses - w0, rd_pulses - r0);
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'h04); exp_q.push_back(8'h03);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01);
        send_byte(8'h5A); send_byte(8'h00);
        rx_valid_i = 1'b0;
        n_checks++;
        if (read_o !== 1'b1 || read_address_o !== 8'h00) begin
            n_fail++;
            $display("FAIL after_bad_read_req: rd=%b addr=%h required 1 00", read_o, read_address_o);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        read_done_i = 1'b1;
        read_data_i = 32'h01020304;
        @(negedge clk_i);
        read_done_i = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back_backpressure();
        exp_q.push_back(8'h00); exp_q.push_back(8'h0D); exp_q.push_back(8'hF0);
        exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
        toggle_ready = 1'b1;
        send_byte(8'h5A); send_byte(8'h3C);
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        read_done_i = 1'b1;
        read_data_i = 32'hCAFEF00D;
        @(negedge clk_i);
        read_done_i = 1'b0;
        wait_idle();
        toggle_ready = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        int w0;
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h11); send_byte(8'h22);
        rx_valid_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_busy: busy=%b required 1", busy_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({rx_ready_o, tx_valid_o, write_o, read_o, busy_o} !== 5'b10000 ||
            write_data_o !== 32'h0 || write_address_o !== 8'h00 || read_address_o !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_values: ctrl=%b wa=%h wd=%h ra=%h required 10000 00 0 00",
                     {rx_ready_o, tx_valid_o, write_o, read_o, busy_o}, write_address_o, write_data_o, read_address_o);
        end
        rst_i = 1'b0;
        w0 = wr_pulses;
        repeat (12) @(negedge clk_i);
        n_checks++;
        if (wr_pulses != w0 || busy_o !== 1'b0 || rx_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_abort: wr=%0d busy=%b rdy=%b required 0 0 1", wr_pulses - w0, busy_o, rx_ready_o);
        end
    endtask

`ifdef BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        exp_q.push_back(8'hED);
        send_byte(8'h5A); send_byte(8'h00);
        rx_valid_i = 1'b0;
        // Pulse cycle, TO cycles in WAIT, response valid on the following cycle.
        k = 0;
        while (!tx_valid_o && k < 60) begin
            @(negedge clk_i);
            k++;
        end
        n_checks++;
        if (k != TO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", k, TO + 1);
        end
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_write_ok();
        test_read_ok();
        test_bus_error();
        test_bad_cmd();
        test_back_to_back_backpressure();
        test_reset_mid();
`ifdef BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_bytes: got %0d required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

UART-to-register-bus bridge: takes a byte stream from a UART receiver, decodes host commands, and issues single read/write transactions on the peripheral register bus. It then returns a status/data response on a byte stream to a UART transmitter. It sits between the debug UART and the peripheral bus, so a host PC can initiate the same register accesses a CPU would.

## Interface
- `TIMEOUT_CYCLES`, default 1024: bus wait limit in clocks; used only with `BRIDGE_TIMEOUT_EN`.
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `rx_data_i` in 8: received byte.
- `rx_valid_i` in 1: `rx_data_i` valid.
- `rx_ready_o` out 1: bridge accepts a byte when `rx_valid_i && rx_ready_o`.
- `tx_data_o` out 8: response byte.
- `tx_valid_o` out 1: `tx_data_o` valid.
- `tx_ready_i` in 1: transmitter consumes the byte when `tx_valid_o && tx_ready_i`.
- `write_o` out 1: one-cycle write request pulse.
- `write_address_o` out 8: register address.
- `write_data_o` out 32: write data.
- `write_done_i` in 1: write completed.
- `write_error_i` in 1: write failed; valid with `write_done_i`.
- `read_o` out 1: one-cycle read request pulse.
- `read_address_o` out 8: register address.
- `read_data_i` in 32: read data; valid with `read_done_i`.
- `read_done_i` in 1: read completed.
- `read_error_i` in 1: read failed; valid with `read_done_i`.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Host frames:
  - Write: `0xA5`, addr, D0, D1, D2, D3 (little-endian).
  - Read: `0x5A`, addr.
- Responses:
  - Write OK: `0x00`.
  - Read OK: `0x00`, D0..D3 (little-endian).
  - Bus error: `0xEE`, with no data bytes.
  - Timeout: `0xED`.
  - Unknown command byte: `0x3F`, with no address phase.
- FSM states:
  - IDLE: accept byte. `0xA5` -> ADDR (write), `0x5A` -> ADDR (read), other -> RESP with `0x3F`.
  - ADDR: accept address byte. Write -> DATA; read -> REQ.
  - DATA: accept 4 bytes via 2-bit byte counter. After the 4th byte -> REQ.
  - REQ: pulse `write_o` or `read_o` for exactly one cycle -> WAIT.
  - WAIT: on the matching `*_done_i`, latch error and read data, load response -> RESP. On timeout, load `0xED` -> RESP.
  - RESP: shift out 1 or 5 bytes. After the last handshake -> IDLE.
- `rx_ready_o` = 1 only in IDLE, ADDR and DATA. Bytes offered in other states are not consumed.
- Address and data outputs hold the latched value from REQ until the next command overwrites them.
- Done inputs for the non-active direction are ignored.
- Done inputs outside WAIT/REQ are ignored.

## Timing
- Reset values:
  - `rx_ready_o` = 1 (IDLE).
  - `tx_valid_o` = 0, `tx_data_o` = 0.
  - `write_o` = 0, `read_o` = 0.
  - Addresses and write data = 0.
  - `busy_o` = 0.
  - FSM in IDLE, counters 0.
- Reset mid-operation aborts the frame. No request pulse and no response byte is emitted afterwards.
- Request latency: the pulse is asserted the cycle after the last frame byte handshake.
- A done arriving in the same cycle as the request pulse is accepted. The response is then valid on the next cycle.
- First response byte: `tx_valid_o` rises the cycle after done is sampled.
- Response byte stability: `tx_data_o` is stable while `tx_valid_o && !tx_ready_i`. The next byte is presented the cycle after each handshake.
- With `tx_ready_i` held high, a 5-byte read response takes 5 consecutive cycles.
- Return to IDLE: `rx_ready_o` rises the cycle after the final tx handshake.
- Simultaneous done and timeout expiry in the same cycle: done wins.
- Timeout counter: loaded to `TIMEOUT_CYCLES-1` in REQ, decremented in WAIT. Expiry is when it reads 0 without a done.

## Configuration
- Macro: `BRIDGE_TIMEOUT_EN`.
- Defined: the timeout counter exists, and WAIT exits with `0xED` after `TIMEOUT_CYCLES` clocks without done.
- Undefined: no counter logic, `TIMEOUT_CYCLES` is unused, and WAIT waits indefinitely for done.

## Test plan
- Write OK: rx `A5 10 78 56 34 12`, done with no error 3 cycles after the pulse -> one `write_o` pulse with addr `0x10` and data `0x12345678`; tx `00`.
- Read OK: rx `5A 04`, `read_data_i` = `0xDEADBEEF` with done -> one `read_o` pulse with addr `0x04`; tx `00 EF BE AD DE`.
- Bus error: rx `5A 08`, done with `read_error_i` = 1 -> tx `EE` only, then `rx_ready_o` = 1.
- Bad command: rx `33` -> tx `3F`; no bus pulse; next frame `5A 00` is processed normally.
- Backpressure and reset: read response with `tx_ready_i` toggling 1/0 every cycle -> each byte held stable until accepted and no byte lost. Asserting `rst_i` during DATA -> outputs return to reset values and no `write_o` pulse follows.
- Timeout (`BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 16): rx `5A 00` with done never asserted -> tx `ED` 16 cycles after the pulse, then IDLE.
